// File: rtl/irq_pending_arbiter.sv
// rtl/irq_pending_arbiter.sv - sticky IRQ pending register with priority-encoded valid/ack presentation
// Optional overflow tracking (ovf/ovf_clr) is built when IRQ_OVERFLOW_EN is defined.
module irq_pending_arbiter #(
    parameter int EDGE_MODE      = 1,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] mask,
    input  logic       irq_ack,
`ifdef IRQ_OVERFLOW_EN
    input  logic [7:0] ovf_clr,
    output logic [7:0] ovf,
`endif
    output logic [7:0] pend,
    output logic       irq_valid,
    output logic [2:0] irq_id,
    output logic       irq_timeout
);

    localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    state_t        state;
    logic [7:0]    req_q;
    logic [7:0]    set_vec;
    logic [7:0]    clr_vec;
    logic [7:0]    pend_nxt;
    logic [7:0]    eligible;
    logic [2:0]    top_idx;
    logic [CW-1:0] cnt;

    always_comb begin
        set_vec = (EDGE_MODE != 0) ? (req & ~req_q) : req;
    end

    // Ack is only honoured while presenting, which also makes it a no-op when irq_valid=0.
    always_comb begin
        clr_vec = '0;
        if (state == PRESENT && irq_ack) begin
            clr_vec[irq_id] = 1'b1;
        end
    end

    // A fresh set in the ack cycle survives the clear so the new event is not lost.
    always_comb begin
        pend_nxt = (pend & ~clr_vec) | set_vec;
    end

    always_comb begin
        eligible = pend & mask;
    end

    always_comb begin
        top_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (eligible[i]) begin
                top_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            req_q       <= '0;
            pend        <= '0;
            irq_valid   <= 1'b0;
            irq_id      <= 3'd0;
            irq_timeout <= 1'b0;
            cnt         <= '0;
        end else begin
            req_q       <= req;
            pend        <= pend_nxt;
            irq_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (|eligible) begin
                        irq_id    <= top_idx;
                        irq_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (irq_ack) begin
                        irq_valid <= 1'b0;
                        state     <= IDLE;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        if (cnt == TO_LAST) begin
                            irq_valid   <= 1'b0;
                            irq_timeout <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    irq_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef IRQ_OVERFLOW_EN
    logic [7:0] ovf_set;

    // A repeat event on a bit that stays pending is recorded; a new set beats a clear request.
    always_comb begin
        ovf_set = set_vec & pend & ~clr_vec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= '0;
        end else begin
            ovf <= (ovf & ~ovf_clr) | ovf_set;
        end
    end
`endif

endmodule

// File: tb/tb_irq_pending_arbiter.sv
// tb/tb_irq_pending_arbiter.sv - directed self-checking bench for irq_pending_arbiter
module tb_irq_pending_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] mask;
    logic       irq_ack;
    logic [7:0] pend;
    logic       irq_valid;
    logic [2:0] irq_id;
    logic       irq_timeout;
`ifdef IRQ_OVERFLOW_EN
    logic [7:0] ovf_clr;
    logic [7:0] ovf;
`endif

    int passed = 0;
    int total  = 0;

    irq_pending_arbiter #(
        .EDGE_MODE     (1),
        .TIMEOUT_CYCLES(15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .mask       (mask),
        .irq_ack    (irq_ack),
`ifdef IRQ_OVERFLOW_EN
        .ovf_clr    (ovf_clr),
        .ovf        (ovf),
`endif
        .pend       (pend),
        .irq_valid  (irq_valid),
        .irq_id     (irq_id),
        .irq_timeout(irq_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        rst     = 1'b1;
        req     = 8'h00;
        mask    = 8'hFF;
        irq_ack = 1'b0;
`ifdef IRQ_OVERFLOW_EN
        ovf_clr = 8'h00;
`endif
        tick();
        tick();
        check("rst_pend", pend, 8'h00);
        check("rst_valid", {7'd0, irq_valid}, 8'd0);
        check("rst_id", {5'd0, irq_id}, 8'd0);
        check("rst_timeout", {7'd0, irq_timeout}, 8'd0);
`ifdef IRQ_OVERFLOW_EN
        check("rst_ovf", ovf, 8'h00);
`endif
        rst = 1'b0;

        // single pulse on bit 2
        req = 8'h04;
        tick();
        req = 8'h00;
        check("t1_pend", pend, 8'h04);
        check("t1_valid_lo", {7'd0, irq_valid}, 8'd0);
        tick();
        check("t1_valid", {7'd0, irq_valid}, 8'd1);
        check("t1_id", {5'd0, irq_id}, 8'd2);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("t1_pend_clr", pend, 8'h00);
        check("t1_valid_clr", {7'd0, irq_valid}, 8'd0);

        // simultaneous 7 and 0, then a higher arrival during presentation
        req = 8'h81;
        tick();
        req = 8'h00;
        tick();
        check("t2_id7", {5'd0, irq_id}, 8'd7);
        check("t2_valid7", {7'd0, irq_valid}, 8'd1);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("t2_pend01", pend, 8'h01);
        check("t2_idle_gap", {7'd0, irq_valid}, 8'd0);
        tick();
        check("t2_valid0", {7'd0, irq_valid}, 8'd1);
        check("t2_id0", {5'd0, irq_id}, 8'd0);
        req = 8'h40;
        tick();
        req = 8'h00;
        check("t2_frozen_id", {5'd0, irq_id}, 8'd0);
        check("t2_pend41", pend, 8'h41);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("t2_pend40", pend, 8'h40);
        check("t2_gap2", {7'd0, irq_valid}, 8'd0);
        tick();
        check("t2_id6", {5'd0, irq_id}, 8'd6);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("t2_pend_empty", pend, 8'h00);

        // masked source stays pending until unmasked; masking mid-presentation is ignored
        mask = 8'h7F;
        req  = 8'h80;
        tick();
        req = 8'h00;
        tick();
        check("t3_pend80", pend, 8'h80);
        check("t3_masked_valid", {7'd0, irq_valid}, 8'd0);
        mask = 8'hFF;
        tick();
        check("t3_valid", {7'd0, irq_valid}, 8'd1);
        check("t3_id7", {5'd0, irq_id}, 8'd7);
        mask = 8'h00;
        tick();
        check("t3_mask_hold_valid", {7'd0, irq_valid}, 8'd1);
        check("t3_mask_hold_id", {5'd0, irq_id}, 8'd7);
        mask    = 8'hFF;
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("t3_pend_clr", pend, 8'h00);

        // timeout after 15 unacknowledged valid cycles
        req = 8'h08;
        tick();
        req = 8'h00;
        tick();
        check("t4_valid", {7'd0, irq_valid}, 8'd1);
        check("t4_id3", {5'd0, irq_id}, 8'd3);
        for (int i = 0; i < 14; i++) begin
            tick();
            check("t4_hold_valid", {7'd0, irq_valid}, 8'd1);
            check("t4_no_timeout", {7'd0, irq_timeout}, 8'd0);
        end
        tick();
        check("t4_withdrawn", {7'd0, irq_valid}, 8'd0);
        check("t4_timeout_pulse", {7'd0, irq_timeout}, 8'd1);
        check("t4_pend_kept", pend, 8'h08);
        tick();
        check("t4_pulse_end", {7'd0, irq_timeout}, 8'd0);
        check("t4_represent", {7'd0, irq_valid}, 8'd1);
        check("t4_represent_id", {5'd0, irq_id}, 8'd3);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("t4_pend_clr", pend, 8'h00);

        // ack coincides with a new edge on the presented bit
        req = 8'h10;
        tick();
        req = 8'h00;
        tick();
        check("t5_id4", {5'd0, irq_id}, 8'd4);
        irq_ack = 1'b1;
        req     = 8'h10;
        tick();
        irq_ack = 1'b0;
        req     = 8'h00;
        check("t5_pend_kept", pend, 8'h10);
        check("t5_gap", {7'd0, irq_valid}, 8'd0);
`ifdef IRQ_OVERFLOW_EN
        check("t5_no_ovf_on_ack", ovf, 8'h00);
`endif
        tick();
        check("t5_represent", {7'd0, irq_valid}, 8'd1);
        check("t5_represent_id", {5'd0, irq_id}, 8'd4);
`ifdef IRQ_OVERFLOW_EN
        req = 8'h10;
        tick();
        req = 8'h00;
        check("t5_ovf_set", ovf, 8'h10);
        ovf_clr = 8'h10;
        tick();
        ovf_clr = 8'h00;
        check("t5_ovf_clr", ovf, 8'h00);
`endif
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("t5_pend_clr", pend, 8'h00);

        // ack while idle does nothing
        mask = 8'h00;
        req  = 8'h02;
        tick();
        req     = 8'h00;
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("t6_idle_ack_pend", pend, 8'h02);
        check("t6_idle_ack_valid", {7'd0, irq_valid}, 8'd0);
        mask = 8'hFF;
        tick();
        check("t6_id1", {5'd0, irq_id}, 8'd1);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("t6_pend_clr", pend, 8'h00);

        // reset during presentation
        req = 8'h20;
        tick();
        req = 8'h00;
        tick();
        check("t7_id5", {5'd0, irq_id}, 8'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t7_pend", pend, 8'h00);
        check("t7_valid", {7'd0, irq_valid}, 8'd0);
        check("t7_id", {5'd0, irq_id}, 8'd0);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("t7_late_ack_valid", {7'd0, irq_valid}, 8'd0);
        check("t7_late_ack_pend", pend, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
